// File: rtl/data_mem_pkg.sv
// Shared definitions for the Data_MEM arbiter: default widths, memory op
// encoding and the arbiter FSM state encoding.
package data_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    // Data_MEM op pin: high reads, low writes (combinationally) into the array.
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant. A lone valid requester always wins; when both
// (or neither) are valid, the requester that did not win last time is chosen.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    // Grant selection: default to the requester that lost last time.
    always_comb begin
        grant = ~last_grant;
        if (valid0 && !valid1) begin
            grant = 1'b0;
        end else if (valid1 && !valid0) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one 256x8 Data_MEM between the CPU load/store stage (req0) and the
// debug/DMA loader (req1). One transaction at a time: IDLE -> ACCESS -> RESP.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; ready is only offered in IDLE and only to the
// requester the arbiter grants. The response is a one-cycle rspN_valid
// strobe two edges after the accepting edge; rsp_rdata is qualified by it.
//
// Every memory-facing output is a flop so that address and write data are
// stable for the whole cycle in which mem_op is low (Data_MEM writes
// combinationally while op is low).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        dbg_state
);

    state_t              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q,         id_d;
    logic                we_q,         we_d;
    logic                mem_op_q,     mem_op_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;

    logic                grant;
    logic                accept;

    rr_arbiter_2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // A transfer happens when the granted requester is valid while idle.
    assign accept = (state_q == IDLE) && (grant ? req1_valid : req0_valid);

    // Ready is combinational from state and grant, suppressed while in reset.
    assign req0_ready = (state_q == IDLE) && !reset && !grant;
    assign req1_ready = (state_q == IDLE) && !reset &&  grant;

    assign rsp0_valid = (state_q == RESP) && !id_q;
    assign rsp1_valid = (state_q == RESP) &&  id_q;

    assign rsp_rdata  = rsp_rdata_q;
    assign mem_op     = mem_op_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;

    // Next-state logic: capture the request on accept, fire one memory cycle,
    // then present the response for exactly one cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        mem_op_d     = mem_op_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_rdata_d  = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ACCESS;
                    last_grant_d = grant;
                    id_d         = grant;
                    we_d         = grant ? req1_we    : req0_we;
                    mem_addr_d   = grant ? req1_addr  : req0_addr;
                    mem_wdata_d  = grant ? req1_wdata : req0_wdata;
                    // op goes low together with the new address/data, never before.
                    mem_op_d     = (grant ? req1_we : req0_we) ? MEM_WRITE : MEM_READ;
                end
            end
            ACCESS: begin
                state_d     = RESP;
                mem_op_d    = MEM_READ;
                rsp_rdata_d = we_q ? '0 : mem_rdata;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_op_d = MEM_READ;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            mem_op_q     <= MEM_READ;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            mem_op_q     <= mem_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural 256x8 Data_MEM model.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_we, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_we, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    data_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Data_MEM model: asynchronous read, write committed while op is low.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_op == MEM_WRITE) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Invariants: a write strobe only in ACCESS, and never two responses at once.
    always @(negedge clk) begin
        if (!reset && mem_op == MEM_WRITE) check("op_low_only_in_access", dbg_state, 2'd1);
        check("rsp_exclusive", rsp0_valid & rsp1_valid, 0);
    end

    task automatic idle_inputs();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    // Pulse reset for two cycles; returns at a falling edge with reset low.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // One transaction from a single requester, checked cycle by cycle.
    task automatic do_txn(input vec_t v);
        int waited = 0;
        if (v.id) begin
            req1_valid = 1; req1_we = v.we; req1_addr = v.addr; req1_wdata = v.wdata;
        end else begin
            req0_valid = 1; req0_we = v.we; req0_addr = v.addr; req0_wdata = v.wdata;
        end
        #1;
        while (!(v.id ? req1_ready : req0_ready) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_within_bound", waited < 10, 1);
        if (waited >= 10) begin
            idle_inputs();
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the request fields after accept: only the accepted values matter.
        idle_inputs();
        req0_addr = AW'($urandom_range(0, 255));
        req1_wdata = DW'($urandom_range(0, 255));
        @(negedge clk);
        check("access_op", mem_op, v.we ? 0 : 1);
        check("access_addr", mem_addr, v.addr);
        if (v.we) check("access_wdata", mem_wdata, v.wdata);
        check("access_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("access_no_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("rsp0_strobe", rsp0_valid, !v.id);
        check("rsp1_strobe", rsp1_valid, v.id);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("resp_op_read", mem_op, 1);
        check("resp_addr_hold", mem_addr, v.addr);
        @(negedge clk);
        check("idle_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h12] = 8'h03;
        mem[8'h40] = 8'h77;

        //            id    we    addr    wdata  exp_rdata
        vecs[0] = '{1'b0, 1'b1, 8'h01, 8'h05, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h12, 8'h00, 8'h03};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hAA, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h11, 8'hAA};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h05};
        vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h77};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'hC3, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hC3};
        vecs[8] = '{1'b0, 1'b0, 8'h33, 8'h00, 8'h00};

        idle_inputs();
        reset = 1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_op", mem_op, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_state", dbg_state, 0);
        reset = 0;
        #1;
        check("post_rst_grant0", {req0_ready, req1_ready}, 2'b10);

        // Single-requester transactions
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Both requesters reading continuously: grants alternate, 3-cycle spacing
        apply_reset();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h40;
        exp_q.push_back(8'h03); exp_q.push_back(8'h77);
        exp_q.push_back(8'h03); exp_q.push_back(8'h77);
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = k[0];
            #1;
            check("rr_ready0", req0_ready, !exp_id);
            check("rr_ready1", req1_ready, exp_id);
            @(posedge clk);
            if (k == 3) begin
                #1;
                idle_inputs();
            end
            @(negedge clk);
            check("rr_addr", mem_addr, exp_id ? 8'h40 : 8'h12);
            check("rr_no_ready", {req0_ready, req1_ready}, 0);
            @(negedge clk);
            check("rr_rsp0", rsp0_valid, !exp_id);
            check("rr_rsp1", rsp1_valid, exp_id);
            check("rr_rdata", rsp_rdata, exp_q.pop_front());
            @(negedge clk);
        end

        // Reset during a write ACCESS drops it and restores req0 priority
        req0_valid = 1; req0_we = 1; req0_addr = 8'h20; req0_wdata = 8'h99;
        #1;
        check("pre_rst_ready0", req0_ready, 1);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("pre_rst_write_op", mem_op, 0);
        reset = 1;
        #1;
        check("mid_rst_op", mem_op, 1);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_ready", {req0_ready, req1_ready}, 0);
        check("mid_rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 0;
        repeat (2) begin
            @(negedge clk);
            check("dropped_rsp", {rsp0_valid, rsp1_valid}, 0);
        end
        req0_valid = 1; req0_we = 0; req0_addr = 8'h12;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h40;
        #1;
        check("after_rst_ready0", req0_ready, 1);
        check("after_rst_ready1", req1_ready, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("after_rst_rsp0", rsp0_valid, 1);
        check("after_rst_rdata", rsp_rdata, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
